// File: rtl/core_pkg.sv
// Purpose: shared types and constants for the dual-slot issue/execute pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

  // Execute-unit class of a slot.
  typedef enum logic [1:0] {
    EXEC_ALU    = 2'd0,
    EXEC_LOAD   = 2'd1,
    EXEC_STORE  = 2'd2,
    EXEC_BRANCH = 2'd3
  } exec_type;

  // Upper-slot opcode [63:58] of a load.
  localparam logic [5:0] OP_LOAD = 6'b010000;

  // Bundle injected into execute when decode is held.
  localparam logic [63:0] NOP_BUNDLE = {3'b111, 29'b0, 3'b111, 29'b0};

  // Memory-handshake FSM states.
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } mem_fsm_t;

  // Load scoreboard geometry.
  localparam int NUM_REGS = 32;
  localparam int SB_W     = 2;

  function automatic logic is_load_op(input logic [5:0] op);
    return op == OP_LOAD;
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Purpose: per-register countdown of in-flight loads plus four source hit lookups.
// Latency: set/decrement visible next cycle; hit lookups are combinational.
// Backpressure: freeze holds every counter (execute stalled).
// Ports: clk/rstn (sync active-low); set_vld/set_idx load the entry with LOAD_LAT;
//        freeze holds counters; src_idx/src_use are the four source lookups;
//        src_hit flags a used source whose counter is nonzero.
module load_scoreboard
  import core_pkg::*;
#(
  parameter int LOAD_LAT = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            set_vld,
  input  logic [4:0]      set_idx,
  input  logic            freeze,
  input  logic [3:0][4:0] src_idx,
  input  logic [3:0]      src_use,
  output logic [3:0]      src_hit
);

  localparam logic [SB_W-1:0] LAT = SB_W'(LOAD_LAT);

  logic [SB_W-1:0] sb_q [NUM_REGS];
  logic [SB_W-1:0] sb_d [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = sb_q[r];
      if (r == 0) begin
        // r0 is hardwired and never waits on a load.
        sb_d[r] = '0;
      end else if (set_vld && (set_idx == 5'(r))) begin
        // A new load wins over the decrement, so re-issue reloads the full latency.
        sb_d[r] = LAT;
      end else if (!freeze && (sb_q[r] != '0)) begin
        sb_d[r] = sb_q[r] - SB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        sb_q[r] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  always_comb begin
    src_hit = '0;
    for (int i = 0; i < 4; i++) begin
      src_hit[i] = src_use[i] && (sb_q[src_idx[i]] != '0);
    end
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Purpose: interlock/stall control for the dual-slot execute stage (load-use, memory wait, bundle errors).
// Latency: interlock combinational; exec_stall, bundle_err, mem_timeout registered (1 cycle).
// Backpressure: interlock holds decode on a load-use hit; exec_stall freezes execute while a load waits on memory.
// Ports: clk/rstn (sync active-low); dec_* bundle from decode with upper/lower source and
//        destination fields; ex_to_mem_ready/mem_ack memory handshake; outputs interlock,
//        exec_stall, sticky bundle_err and sticky mem_timeout.
module issue_hazard_ctrl
  import core_pkg::*;
#(
  parameter int LOAD_LAT    = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       dec_valid,
  input  logic       dec_is_load,
  input  logic [4:0] u_ra,
  input  logic [4:0] u_rb,
  input  logic       u_ra_use,
  input  logic       u_rb_use,
  input  logic [4:0] l_ra,
  input  logic [4:0] l_rb,
  input  logic       l_ra_use,
  input  logic       l_rb_use,
  input  logic [4:0] u_rt,
  input  logic [4:0] l_rt,
  input  logic       u_rt_flag,
  input  logic       l_rt_flag,
  input  logic       ex_to_mem_ready,
  input  logic       mem_ack,
  output logic       interlock,
  output logic       exec_stall,
  output logic       bundle_err,
  output logic       mem_timeout
);

  localparam logic [7:0] TO_VAL = 8'(MEM_TIMEOUT);

  mem_fsm_t   state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       bundle_err_q, bundle_err_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic [3:0] src_hit;
  logic       issue;
  logic       load_set;
  logic       raw_hit;
  logic       waw_hit;

  load_scoreboard #(
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .rstn    (rstn),
    .set_vld (load_set),
    .set_idx (u_rt),
    .freeze  (exec_stall),
    .src_idx ({l_rb, l_ra, u_rb, u_ra}),
    .src_use ({l_rb_use, l_ra_use, u_rb_use, u_ra_use}),
    .src_hit (src_hit)
  );

  // Forced during reset so nothing issues against a half-cleared scoreboard.
  assign interlock  = !rstn || (dec_valid && (src_hit != '0));
  assign issue      = dec_valid && !interlock && !exec_stall;
  assign load_set   = issue && dec_is_load && u_rt_flag && (u_rt != '0);
  assign exec_stall = (state_q == WAIT_MEM);

  // Lower slot reading the upper slot's result in the same bundle cannot be forwarded.
  assign raw_hit = u_rt_flag && (u_rt != '0) &&
                   ((l_ra_use && (l_ra == u_rt)) || (l_rb_use && (l_rb == u_rt)));
  assign waw_hit = u_rt_flag && l_rt_flag && (u_rt == l_rt);

  always_comb begin
    bundle_err_d = bundle_err_q;
    if (dec_valid && (raw_hit || waw_hit)) begin
      bundle_err_d = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_timeout_d = mem_timeout_q;
    cnt_inc       = cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        // A load whose data comes back in the same cycle never stalls.
        if (ex_to_mem_ready && !mem_ack) begin
          state_d = WAIT_MEM;
          cnt_d   = '0;
        end
      end
      WAIT_MEM: begin
        if (mem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Saturate so a hung memory keeps the flag without wrapping.
          if (cnt_q != TO_VAL) begin
            cnt_d = cnt_inc;
          end
          if (cnt_inc == TO_VAL) begin
            mem_timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bundle_err_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bundle_err_q  <= bundle_err_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign bundle_err  = bundle_err_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
- Sequences the dual-slot (upper [63:32] / lower [31:0]) execute stage by generating its `interlock` and `exec_stall` controls.
- Holds a per-register load scoreboard that interlocks a bundle whose sources depend on an in-flight load.
- Runs a memory-handshake FSM that freezes execute while a load is outstanding in memory.
- Sits between decode/register-read and execute; execute samples both outputs in the same cycle they are driven.

Parameters:
- LOAD_LAT, 2, cycles after a load leaves execute before its result is forwardable (1..3).
- MEM_TIMEOUT, 255, cycles in WAIT_MEM before `mem_timeout` is raised (8-bit counter).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- dec_valid  in  1  decode presents a valid bundle.
- dec_is_load  in  1  bundle opcode [63:58]==6'b010000 (load, upper slot).
- u_ra, u_rb  in  5 each  upper source registers.
- u_ra_use, u_rb_use  in  1 each  upper source actually read.
- l_ra, l_rb  in  5 each  lower source registers.
- l_ra_use, l_rb_use  in  1 each  lower source actually read.
- u_rt, l_rt  in  5 each  destination registers.
- u_rt_flag, l_rt_flag  in  1 each  destination write enables.
- ex_to_mem_ready  in  1  execute has latched a load this cycle (from execute stage).
- mem_ack  in  1  memory returned load data.
- interlock  out  1  combinational; hold decode and inject a bubble.
- exec_stall  out  1  registered; freeze execute.
- bundle_err  out  1  sticky; intra-bundle RAW detected.
- mem_timeout  out  1  sticky; memory exceeded MEM_TIMEOUT.

Behaviour:
- Reset (`rstn`=0 at posedge): scoreboard all 0; FSM=IDLE; `exec_stall`=0; `bundle_err`=0; `mem_timeout`=0; timeout counter 0.
- While `rstn`=0, `interlock` is forced to 1, so no bundle issues during reset.
- Scoreboard: 32 entries, 2-bit down-counter `sb[r]`; `r`=0 is never tracked (reads as 0).
- A source hits when its `_use` bit is 1 and `sb[src]`!=0.
- `interlock` = `dec_valid` & (any of the four sources hits).
- Issue occurs when `dec_valid` & ~`interlock` & ~`exec_stall`.
  - On issue with `dec_is_load` & `u_rt_flag` & `u_rt`!=0: `sb[u_rt]` <= LOAD_LAT.
  - Non-load writes are never tracked (full forwarding assumed).
- Decrement: each cycle with `exec_stall`=0, every nonzero entry not being set this cycle decrements by 1.
  - While `exec_stall`=1, counters hold.
  - A set on an entry takes priority over its decrement.
- Re-issue of a load to a register whose counter is still nonzero reloads it to LOAD_LAT.
- Intra-bundle RAW:
  - Condition: `l_ra`/`l_rb` used, equal to `u_rt`, `u_rt_flag`=1, and `u_rt`!=0.
  - On a valid bundle, this sets `bundle_err` (sticky until reset).
  - It does not interlock.
- WAW: `u_rt`==`l_rt` with both flags set also sets `bundle_err`.
- FSM states IDLE and WAIT_MEM:
  - IDLE -> WAIT_MEM when `ex_to_mem_ready`=1 and `mem_ack`=0. `exec_stall` goes 1 in the next cycle; the counter clears.
  - IDLE stays IDLE when `ex_to_mem_ready`=1 and `mem_ack`=1 in the same cycle; no stall.
  - WAIT_MEM -> IDLE on `mem_ack`=1. `exec_stall` drops in the next cycle.
  - In WAIT_MEM, the counter increments each cycle. On reaching MEM_TIMEOUT, `mem_timeout` is set; the FSM stays in WAIT_MEM.
  - `mem_ack` in IDLE without a pending load is ignored.
- `exec_stall` = (state==WAIT_MEM), registered.
- Reset asserted mid-WAIT_MEM returns the FSM to IDLE and clears the scoreboard the next cycle.

Decomposition:
- Shared package `core_pkg` holds:
  - `exec_type` enum.
  - OP_LOAD = 6'b010000.
  - the NOP bundle constant {3'b111, 29'b0, 3'b111, 29'b0}.
  - `mem_fsm_t` {IDLE, WAIT_MEM}.
- One natural sub-module: `load_scoreboard`, the 32x2-bit counter array with set/decrement/freeze and 4 hit lookups.
- The FSM and error logic stay in the top module.

Test Plan:
- Load r5 issued (LOAD_LAT=2), next bundle reads `u_ra`=5 -> `interlock`=1 for 2 cycles, then 0. The bundle issues on the 3rd cycle.
- Load with `u_rt`=0, next bundle reads r0 -> `interlock` never asserts; `sb` unchanged.
- `ex_to_mem_ready`=1 with `mem_ack`=0, then `mem_ack` 4 cycles later -> `exec_stall`=1 for exactly 4 cycles. `sb[r5]` holds at its value during the stall.
- `ex_to_mem_ready` and `mem_ack` in the same cycle -> `exec_stall` stays 0.
- Bundle with `u_rt`=7, `u_rt_flag`=1, `l_ra`=7, `l_ra_use`=1 -> `bundle_err`=1 next cycle and remains set until `rstn`=0.
- MEM_TIMEOUT=8 override, no `mem_ack` -> `mem_timeout`=1 after 8 WAIT_MEM cycles. Assert `rstn`=0 -> next cycle `exec_stall`=0, FSM=IDLE, flags cleared.
